// File: rtl/pipe_pkg.sv
// Shared types and constants for the 16-bit, 8-register pipeline interlock.
package pipe_pkg;

    // Width of the decoded control bundle and of the hazard mask.
    localparam int CTL_W = 21;

    // Encoding of the no-operation instruction used for IF/ID bubbles.
    localparam logic [15:0] NOP = 16'h0000;

    // RUN: normal fetch. DRAIN: fetches still in flight after a flush are discarded.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } interlock_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat16_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // 8-bit variant for the consecutive-stall run length.
    function automatic logic [7:0] sat8_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/pipeline_interlock_stall_watchdog.sv
// Stall bookkeeping: stall-edge flag, saturating total stall count,
// consecutive-stall run length and a sticky stuck-stall timeout.
module stall_watchdog #(
    parameter int MAX_STALL = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush_or_advance,
    output logic        stall_active,
    output logic [15:0] stall_cycles,
    output logic        stall_timeout
);
    import pipe_pkg::*;

    // Threshold compared against the run length after it has been bumped.
    localparam logic [7:0] STALL_LIMIT = 8'(MAX_STALL);

    logic        active_q,  active_d;
    logic [15:0] total_q,   total_d;
    logic [7:0]  run_len_q, run_len_d;
    logic        timeout_q, timeout_d;

    // Next-state: a stall extends the run, anything else ends it; timeout never clears.
    always_comb begin
        active_d  = active_q;
        total_d   = total_q;
        run_len_d = run_len_q;
        timeout_d = timeout_q;
        if (stall) begin
            active_d  = 1'b1;
            total_d   = sat16_inc(total_q);
            run_len_d = sat8_inc(run_len_q);
            if (run_len_d >= STALL_LIMIT) begin
                timeout_d = 1'b1;
            end
        end else if (flush_or_advance) begin
            active_d  = 1'b0;
            run_len_d = 8'd0;
        end
    end

    // State registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            total_q   <= 16'd0;
            run_len_q <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            total_q   <= total_d;
            run_len_q <= run_len_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_active  = active_q;
    assign stall_cycles  = total_q;
    assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipeline_interlock.sv
// Applies load-use stalls and branch flushes to the PC, IF/ID and ID/EX
// registers. Flush beats stall beats advance; every output is registered.
module pipeline_interlock #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          CTL_W     = pipe_pkg::CTL_W,
    parameter int          FLUSH_CYC = 1,
    parameter int          MAX_STALL = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CTL_W-1:0] hazard_ctl,
    input  logic             pc_stop,
    input  logic             branch_taken,
    input  logic [15:0]      branch_target,
    input  logic [15:0]      if_instr,
    input  logic [CTL_W-1:0] id_ctl,
    output logic [15:0]      pc,
    output logic [15:0]      if_id_instr,
    output logic [15:0]      if_id_pc,
    output logic             if_id_valid,
    output logic [CTL_W-1:0] id_ex_ctl,
    output logic             id_ex_valid,
    output logic             stall_active,
    output logic [15:0]      stall_cycles,
    output logic             stall_timeout
);
    import pipe_pkg::*;

    // Number of post-flush fetches to throw away (imem latency cover).
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYC);

    interlock_state_t state_q;
    logic [1:0]       flush_cnt_q;
    logic [15:0]      pc_q;
    logic [15:0]      if_id_instr_q;
    logic [15:0]      if_id_pc_q;
    logic             if_id_valid_q;
    logic [CTL_W-1:0] id_ex_ctl_q;
    logic             id_ex_valid_q;

    logic             stall;
    logic             advance;
    logic [CTL_W-1:0] masked_ctl;

    // A flush always wins, so a stall only counts when no branch is taken.
    assign stall      = !branch_taken && !pc_stop;
    assign advance    = !branch_taken &&  pc_stop;
    assign masked_ctl = id_ctl & hazard_ctl;

    // Pipeline-register FSM: flush, stall or advance on each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            flush_cnt_q   <= 2'd0;
            pc_q          <= RESET_PC;
            if_id_instr_q <= NOP;
            if_id_pc_q    <= 16'h0000;
            if_id_valid_q <= 1'b0;
            id_ex_ctl_q   <= '0;
            id_ex_valid_q <= 1'b0;
        end else if (branch_taken) begin
            // Redirect fetch and squash both stages regardless of pc_stop.
            pc_q          <= branch_target;
            if_id_instr_q <= NOP;
            if_id_valid_q <= 1'b0;
            id_ex_ctl_q   <= '0;
            id_ex_valid_q <= 1'b0;
            flush_cnt_q   <= FLUSH_INIT;
            state_q       <= (FLUSH_CYC > 0) ? DRAIN : RUN;
        end else if (stall) begin
            // Hold fetch and IF/ID; send a bubble carrying the masked controls.
            id_ex_ctl_q   <= masked_ctl;
            id_ex_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_q + 16'd1;
            if_id_pc_q    <= pc_q;
            id_ex_ctl_q   <= if_id_valid_q ? masked_ctl : '0;
            id_ex_valid_q <= if_id_valid_q;
            case (state_q)
                DRAIN: begin
                    // Instruction arriving now was fetched from the stale path.
                    if_id_instr_q <= NOP;
                    if_id_valid_q <= 1'b0;
                    flush_cnt_q   <= flush_cnt_q - 2'd1;
                    if (flush_cnt_q <= 2'd1) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    if_id_instr_q <= if_instr;
                    if_id_valid_q <= 1'b1;
                end
            endcase
        end
    end

    stall_watchdog #(
        .MAX_STALL (MAX_STALL)
    ) u_watchdog (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .flush_or_advance (branch_taken || advance),
        .stall_active     (stall_active),
        .stall_cycles     (stall_cycles),
        .stall_timeout    (stall_timeout)
    );

    assign pc          = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_valid = if_id_valid_q;
    assign id_ex_ctl   = id_ex_ctl_q;
    assign id_ex_valid = id_ex_valid_q;

endmodule

// File: doc/pipeline_interlock.md
Name: pipeline_interlock

Overview:
- Consumer side of the load-use hazard interface: applies the hazard mask and PC-hold request to the PC, IF/ID and ID/EX pipeline registers.
- Also applies branch flushes, which take priority over stalls.
- Sits between fetch/decode and the execute stage of the 16-bit, 8-register pipeline.
- Also provides stall performance counting and a stuck-stall watchdog.

Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.
- CTL_W, 21, width of the decoded control bundle and of the hazard mask.
- FLUSH_CYC, 1, cycles after a flush during which fetched instructions are discarded; covers synchronous imem latency; range 0..3.
- MAX_STALL, 8, consecutive stall cycles that trigger stall_timeout; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hazard_ctl  in  CTL_W  per-bit control mask from hazard detection; 0 clears the matching ID/EX control bit.
- pc_stop  in  1  0 = hold PC and IF/ID (stall); 1 = advance.
- branch_taken  in  1  flush request from EX.
- branch_target  in  16  PC loaded on flush.
- if_instr  in  16  instruction fetched at pc.
- id_ctl  in  CTL_W  decoded controls for the instruction in IF/ID.
- pc  out  16  fetch address.
- if_id_instr  out  16  IF/ID instruction.
- if_id_pc  out  16  IF/ID PC.
- if_id_valid  out  1  IF/ID holds a live instruction.
- id_ex_ctl  out  CTL_W  ID/EX control bundle.
- id_ex_valid  out  1  ID/EX holds a live instruction.
- stall_active  out  1  registered; 1 during a cycle following a stall edge.
- stall_cycles  out  16  saturating count of stall cycles.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, rst_n=0), all outputs at once:
  - pc=RESET_PC; if_id_instr=NOP; if_id_pc=0; if_id_valid=0.
  - id_ex_ctl=0; id_ex_valid=0.
  - stall_active=0; stall_cycles=0; stall_timeout=0.
  - state=RUN; flush_cnt=0; run_len=0.
  - Reset mid-stall or mid-flush discards everything; there is no resumption.
- Per rising edge, priority is FLUSH > STALL > RUN.
- FLUSH (branch_taken=1, any state, regardless of pc_stop):
  - pc<=branch_target.
  - if_id_valid<=0; if_id_instr<=NOP.
  - id_ex_ctl<=0; id_ex_valid<=0.
  - flush_cnt<=FLUSH_CYC; state<=DRAIN if FLUSH_CYC>0, else RUN.
  - Consecutive stall count resets to 0. Not counted as a stall.
- STALL (branch_taken=0, pc_stop=0):
  - pc, if_id_* hold.
  - id_ex_ctl<=id_ctl & hazard_ctl; id_ex_valid<=0 (bubble).
  - stall_active<=1; stall_cycles<=sat16(+1).
  - Consecutive count +1 (saturates at 255). On reaching MAX_STALL, stall_timeout<=1; it stays 1 until reset.
  - Stalling during DRAIN does not decrement flush_cnt.
- RUN/DRAIN advance (branch_taken=0, pc_stop=1):
  - pc<=pc+1, 16-bit wrap (16'hFFFF -> 16'h0000).
  - if_id_instr<=if_instr; if_id_pc<=pc.
  - if_id_valid<=1 in RUN. In DRAIN, if_id_valid<=0, instruction forced to NOP, flush_cnt-1; state->RUN when flush_cnt reaches 0.
  - id_ex_ctl<=if_id_valid ? (id_ctl & hazard_ctl) : 0.
  - id_ex_valid<=if_id_valid.
  - stall_active<=0; consecutive count<=0.
- Latency: one cycle from inputs to every registered output. No combinational input-to-output paths.
- States: RUN, DRAIN. STALL and FLUSH are edge actions, not states.

Decomposition:
- Shared package pipe_pkg:
  - CTL_W=21, NOP=16'h0000.
  - Enum interlock_state_t {RUN, DRAIN}.
  - Function sat16_inc.
- One natural sub-module: stall_watchdog. It holds the consecutive counter, the stall_cycles saturating counter and the sticky timeout; inputs are stall, flush_or_advance and MAX_STALL.

Test Plan:
- Reset then 4 advance cycles with if_instr=16'h1111..16'h4444 -> pc=4; if_id_instr=16'h4444, if_id_pc=3; id_ex_valid=1 from cycle 2.
- Load-use: pc_stop=0, hazard_ctl=0 for 1 cycle at pc=5 -> pc and if_id held for one cycle; id_ex_ctl=0, id_ex_valid=0; stall_cycles=1; then the instruction proceeds.
- Flush with FLUSH_CYC=1, branch_target=16'h0040, during a stall -> pc=16'h0040; both valids 0 next cycle; next fetched instruction discarded; first valid IF/ID has if_id_pc=16'h0041.
- MAX_STALL=8, pc_stop=0 held for 8 cycles -> stall_timeout=1 at the 8th edge; it stays 1 after release; stall_cycles=8.
- PC wrap: reset with RESET_PC=16'hFFFF, advance once -> pc=16'h0000, if_id_pc=16'hFFFF.
- Assert rst_n=0 mid-DRAIN for a fraction of a cycle -> all outputs return to reset values immediately, without waiting for clk.
